commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Parametrised on-chip commit-trace capture block for SingleCycleCPU; a synthesizable successor to printing per-cycle signals from the bench.
- Records one entry per retired instruction: PC, instruction, rd, writeback data, regwrite flag and a cycle timestamp.
- Supports free-run, stop-on-full and PC-triggered pre/post capture modes.
- Trace is drained through a valid/ready read port by the bench or a debug host.

Parameters:
- XLEN, 32, width of PC and writeback data.
- DEPTH, 16, number of trace entries; power of two, at least 2.
- TS_W, 16, timestamp counter width.
- PC_W, $clog2(DEPTH)+1, width of the count and post-trigger fields (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- start  in  1  asynchronous active-low reset (0 = reset, same port as the CPU).
- retire_valid  in  1  one instruction retires this cycle.
- retire_pc  in  XLEN  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- retire_rd  in  5  destination register.
- retire_wdata  in  XLEN  writeback data.
- retire_regwrite  in  1  regwrite flag.
- arm  in  1  single-cycle pulse that starts a capture.
- halt  in  1  forces the DONE state.
- cfg_circular  in  1  0 = stop when full, 1 = overwrite oldest.
- trig_en  in  1  enables PC-trigger mode.
- trig_pc  in  XLEN  trigger PC.
- post_count  in  PC_W  entries to capture after the trigger entry, saturated to DEPTH-1.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  head entry available.
- rd_pc, rd_instr, rd_rd, rd_wdata, rd_regwrite, rd_ts  out  widths as the retire fields plus TS_W  head entry fields.
- count  out  PC_W  entries held, 0..DEPTH.
- overflow  out  1  sticky; an entry was overwritten.
- triggered  out  1  sticky; the trigger PC was hit.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

Behaviour:
- Reset (start=0, asynchronous):
  - state=IDLE; count, write and read pointers, overflow, triggered and the timestamp counter all 0.
  - rd_valid=0; rd_* fields 0.
- Timestamp counter:
  - Free-running, increments every cycle out of reset, wraps modulo 2^TS_W.
  - The entry captured in cycle N carries the counter value of cycle N.
- arm, accepted only in IDLE or DONE:
  - Next cycle: count, pointers, overflow and triggered clear.
  - state goes to ARMED if trig_en=1, otherwise CAPTURE.
  - arm in ARMED or CAPTURE is ignored.
- Capture latency: an entry is written on the same edge on which retire_valid is sampled high. count reflects it in the following cycle.
- ARMED:
  - Every retire is written circularly. When full, the oldest entry is dropped with no overflow flag (pre-trigger history).
  - On retire_valid && retire_pc==trig_pc: that entry is written, triggered<=1, post counter loads saturated post_count.
  - If post_count==0, next state is DONE; otherwise CAPTURE.
- CAPTURE with trig_en=1:
  - Each retire is written and decrements the post counter; circular overwrite is allowed.
  - Goes to DONE after the write that brings the counter to 0.
- CAPTURE with trig_en=0, cfg_circular=0: writes until count==DEPTH, then DONE. The entry arriving when full is dropped.
- CAPTURE with trig_en=0, cfg_circular=1: runs indefinitely; each write while full overwrites the oldest entry and sets overflow.
- halt: from ARMED or CAPTURE goes to DONE next cycle. A retire in the same cycle as halt is still captured. halt takes priority over the trigger transition.
- Read port:
  - rd_valid = (count!=0) && state is IDLE or DONE; no reads during capture.
  - Read is show-ahead: the rd_* fields show the oldest entry combinationally.
  - rd_valid && rd_ready pops the entry; count decrements next cycle.
  - DONE with count reaching 0 stays DONE; only arm or reset leaves DONE.
- trig_en and cfg_circular are sampled at arm. Changes during capture are ignored; the latched copies are used.
- Reset mid-capture discards all entries immediately.
- Pointers are log2(DEPTH) bits and wrap naturally. count never exceeds DEPTH.

Test Plan:
- Stop-on-full: DEPTH=4, cfg_circular=0, trig_en=0, arm, then 6 retires with PC 0x00,0x04..0x14.
  - Required: DONE; count=4; overflow=0.
  - Draining with rd_ready=1 returns PC 0x00,0x04,0x08,0x0C in order; rd_valid drops after 4 pops.
- Circular overwrite: same stimulus with cfg_circular=1, then halt.
  - Required: count=4; overflow=1; drain returns 0x08,0x0C,0x10,0x14.
- Trigger with post-capture: trig_en=1, trig_pc=0x20, post_count=2, retires at PC 0x00..0x30 step 4.
  - Required: triggered=1; DONE after the 0x28 retire.
  - Drain returns 0x1C,0x20,0x24,0x28 (one pre-trigger entry plus trigger and post), count=4.
- Timestamp and fields: retire in cycles 3 and 7 after reset, instr 0x00500093, rd=1, wdata=5, regwrite=1.
  - Required: rd_ts values 3 then 7; all fields match; rd_regwrite=1.
- Reset mid-capture: arm, 2 retires, start=0 for one cycle.
  - Required: immediately count=0, state=IDLE, rd_valid=0; after release the timestamp restarts at 0.
- Backpressure and arm guard: in DONE with count=3, hold rd_ready=0 for 5 cycles, then pulse it 3 times.
  - Required: head fields stable while rd_ready=0; count steps 3,2,1,0.
  - arm during CAPTURE is ignored, so count is not cleared.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: one entry per retire (free-run, stop-on-full, PC-trigger pre/post); entry written on the retire edge.
// Show-ahead valid/ready drain, only in IDLE/DONE; the consumer stalls the head by holding rd_ready low.
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
    parameter int PC_W  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            start,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic [31:0]     retire_instr,
    input  logic [4:0]      retire_rd,
    input  logic [XLEN-1:0] retire_wdata,
    input  logic            retire_regwrite,
    input  logic            arm,
    input  logic            halt,
    input  logic            cfg_circular,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [PC_W-1:0] post_count,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic [4:0]      rd_rd,
    output logic [XLEN-1:0] rd_wdata,
    output logic            rd_regwrite,
    output logic [TS_W-1:0] rd_ts,
    output logic [PC_W-1:0] count,
    output logic            overflow,
    output logic            triggered,
    output logic [1:0]      state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [PC_W-1:0] C_FULL     = PC_W'(DEPTH);
    localparam logic [PC_W-1:0] C_POST_MAX = PC_W'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            regwrite;
        logic [TS_W-1:0] ts;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [1:0]      r_state;
    logic [PC_W-1:0] r_cnt;
    logic [PC_W-1:0] r_post;
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic            r_ovf;
    logic            r_trig;
    logic            r_ten;
    logic            r_circ;
    logic [TS_W-1:0] r_ts;

    logic            w_full;
    logic            w_capturing;
    logic            w_stop_full;
    logic            w_wr;
    logic            w_hit;
    logic            w_pop;
    logic            w_arm_ok;
    logic [PC_W-1:0] w_post_sat;
    logic [1:0]      w_state_nxt;
    entry_t          w_head;
    entry_t          w_new;

    assign w_full      = (r_cnt == C_FULL);
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    // Stop-on-full mode discards anything arriving once the buffer is full.
    assign w_stop_full = (r_state == S_CAPTURE) && !r_ten && !r_circ && w_full;
    assign w_wr        = w_capturing && retire_valid && !w_stop_full;
    assign w_hit       = (r_state == S_ARMED) && retire_valid && (retire_pc == trig_pc);
    assign w_arm_ok    = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_post_sat  = (post_count > C_POST_MAX) ? C_POST_MAX : post_count;
    assign rd_valid    = (r_cnt != '0) && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_pop       = rd_valid && rd_ready;

    assign w_new = '{pc: retire_pc, instr: retire_instr, rd: retire_rd,
                     wdata: retire_wdata, regwrite: retire_regwrite, ts: r_ts};
    assign w_head = (r_cnt != '0) ? r_mem[r_rp] : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ARMED: begin
                if (halt)
                    w_state_nxt = S_DONE;
                else if (w_hit)
                    w_state_nxt = (w_post_sat == '0) ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (halt)
                    w_state_nxt = S_DONE;
                else if (r_ten && w_wr && (r_post == PC_W'(1)))
                    w_state_nxt = S_DONE;
                else if (!r_ten && !r_circ && (w_full || (w_wr && (r_cnt == C_FULL - PC_W'(1)))))
                    w_state_nxt = S_DONE;
            end
            default: begin
                if (w_arm_ok)
                    w_state_nxt = trig_en ? S_ARMED : S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= w_new;
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_post  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_ovf   <= 1'b0;
            r_trig  <= 1'b0;
            r_ten   <= 1'b0;
            r_circ  <= 1'b0;
            r_ts    <= '0;
        end else begin
            r_ts    <= r_ts + TS_W'(1);
            r_state <= w_state_nxt;
            if (w_arm_ok) begin
                r_cnt  <= '0;
                r_post <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                r_ovf  <= 1'b0;
                r_trig <= 1'b0;
                r_ten  <= trig_en;
                r_circ <= cfg_circular;
            end else begin
                if (w_wr)
                    r_wp <= r_wp + AW'(1);
                // A write into a full buffer retires the oldest entry instead of growing count.
                if ((w_wr && w_full) || w_pop)
                    r_rp <= r_rp + AW'(1);
                if (w_wr && !w_full)
                    r_cnt <= r_cnt + PC_W'(1);
                else if (w_pop)
                    r_cnt <= r_cnt - PC_W'(1);
                if (w_wr && w_full && (r_state == S_CAPTURE))
                    r_ovf <= 1'b1;
                if (w_hit) begin
                    r_trig <= 1'b1;
                    r_post <= w_post_sat;
                end else if ((r_state == S_CAPTURE) && r_ten && w_wr) begin
                    r_post <= r_post - PC_W'(1);
                end
            end
        end
    end

    assign rd_pc       = w_head.pc;
    assign rd_instr    = w_head.instr;
    assign rd_rd       = w_head.rd;
    assign rd_wdata    = w_head.wdata;
    assign rd_regwrite = w_head.regwrite;
    assign rd_ts       = w_head.ts;
    assign count       = r_cnt;
    assign overflow    = r_ovf;
    assign triggered   = r_trig;
    assign state       = r_state;

endmodule
